// File: rtl/ps2_joy_pkg.sv
// Shared constants for the PS/2 keyboard joystick path: scancodes, joystick
// bit positions, receiver states and the key lookup used by the decoder.
package ps2_joy_pkg;

  localparam int JOY_W = 10;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;
  localparam logic [7:0] SC_ACK   = 8'hFA;
  localparam logic [7:0] SC_BAT   = 8'hAA;
  localparam logic [7:0] SC_OVR0  = 8'h00;
  localparam logic [7:0] SC_OVR1  = 8'hFF;

  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_5     = 8'h2E;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_TAB   = 8'h0D;

  localparam logic [3:0] JB_FIRE   = 4'd0;
  localparam logic [3:0] JB_START1 = 4'd1;
  localparam logic [3:0] JB_START2 = 4'd2;
  localparam logic [3:0] JB_COIN   = 4'd3;
  localparam logic [3:0] JB_UP     = 4'd4;
  localparam logic [3:0] JB_DOWN   = 4'd5;
  localparam logic [3:0] JB_LEFT   = 4'd6;
  localparam logic [3:0] JB_RIGHT  = 4'd7;
  localparam logic [3:0] JB_ESC    = 4'd8;
  localparam logic [3:0] JB_TAB    = 4'd9;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rxState_e;

  typedef struct packed {
    logic       hit;
    logic [3:0] bitIdx;
  } keyHit_t;

  // Arrows only exist behind E0; the same codes without it are keypad keys.
  function automatic keyHit_t mapKey(input logic ext, input logic [7:0] code);
    keyHit_t r;
    r.hit    = 1'b1;
    r.bitIdx = JB_FIRE;
    if (ext) begin
      case (code)
        SC_UP:    r.bitIdx = JB_UP;
        SC_DOWN:  r.bitIdx = JB_DOWN;
        SC_LEFT:  r.bitIdx = JB_LEFT;
        SC_RIGHT: r.bitIdx = JB_RIGHT;
        default:  r.hit    = 1'b0;
      endcase
    end else begin
      case (code)
        SC_SPACE: r.bitIdx = JB_FIRE;
        SC_1:     r.bitIdx = JB_START1;
        SC_2:     r.bitIdx = JB_START2;
        SC_5:     r.bitIdx = JB_COIN;
        SC_ESC:   r.bitIdx = JB_ESC;
        SC_TAB:   r.bitIdx = JB_TAB;
        default:  r.hit    = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronises and deglitches the line pair,
// frames 11-bit words, checks odd parity and aborts stalled frames.
module ps2_rx
  import ps2_joy_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 18000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       ps2Clk_i,
  input  logic       ps2Data_i,
  output logic [7:0] rxByte_o,
  output logic       byteStb_o,
  output logic       errStb_o
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clkSync_q;
  logic [1:0]    dataSync_q;
  logic [FW-1:0] filtCnt_q;
  logic          clkF_q;
  logic          clkFPrev_q;
  logic [TW-1:0] toCnt_q;
  rxState_e      state_q;
  logic [7:0]    shift_q;
  logic [2:0]    bitCnt_q;
  logic          parityOk_q;
  logic [7:0]    rxByte_q;
  logic          byteStb_q;
  logic          errStb_q;

  logic fall;
  logic dataBit;
  logic timeoutHit;

  assign fall       = clkFPrev_q & ~clkF_q;
  assign dataBit    = dataSync_q[1];
  assign timeoutHit = (state_q != RX_IDLE) && !fall &&
                      (toCnt_q == TW'(TIMEOUT_CYCLES - 1));

  // The idle bus is high, so synchronisers and filter come out of reset high.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      clkSync_q  <= 2'b11;
      dataSync_q <= 2'b11;
      filtCnt_q  <= '0;
      clkF_q     <= 1'b1;
      clkFPrev_q <= 1'b1;
    end else begin
      clkSync_q  <= {clkSync_q[0], ps2Clk_i};
      dataSync_q <= {dataSync_q[0], ps2Data_i};
      clkFPrev_q <= clkF_q;
      if (clkSync_q[1] != clkF_q) begin
        if (filtCnt_q == FW'(FILTER_LEN - 1)) begin
          clkF_q    <= clkSync_q[1];
          filtCnt_q <= '0;
        end else begin
          filtCnt_q <= filtCnt_q + 1'b1;
        end
      end else begin
        filtCnt_q <= '0;
      end
    end
  end

  // Counter holds "cycles since last fall", so the abort lands exactly
  // TIMEOUT_CYCLES after that fall once registered.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      toCnt_q <= '0;
    end else if (fall) begin
      toCnt_q <= TW'(1);
    end else if (state_q == RX_IDLE) begin
      toCnt_q <= '0;
    end else begin
      toCnt_q <= toCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= RX_IDLE;
      shift_q    <= '0;
      bitCnt_q   <= '0;
      parityOk_q <= 1'b0;
      rxByte_q   <= '0;
      byteStb_q  <= 1'b0;
      errStb_q   <= 1'b0;
    end else begin
      byteStb_q <= 1'b0;
      errStb_q  <= 1'b0;
      if (timeoutHit) begin
        state_q  <= RX_IDLE;
        errStb_q <= 1'b1;
      end else if (fall) begin
        case (state_q)
          RX_IDLE: begin
            if (!dataBit) begin
              state_q  <= RX_DATA;
              bitCnt_q <= '0;
            end
          end
          RX_DATA: begin
            shift_q  <= {dataBit, shift_q[7:1]};
            bitCnt_q <= bitCnt_q + 1'b1;
            if (bitCnt_q == 3'd7) begin
              state_q <= RX_PARITY;
            end
          end
          RX_PARITY: begin
            parityOk_q <= ^{shift_q, dataBit};
            state_q    <= RX_STOP;
          end
          RX_STOP: begin
            if (dataBit && parityOk_q) begin
              rxByte_q  <= shift_q;
              byteStb_q <= 1'b1;
            end else begin
              errStb_q <= 1'b1;
            end
            state_q <= RX_IDLE;
          end
          default: state_q <= RX_IDLE;
        endcase
      end
    end
  end

  assign rxByte_o  = rxByte_q;
  assign byteStb_o = byteStb_q;
  assign errStb_o  = errStb_q;

endmodule

// File: rtl/ps2_joy_decoder.sv
// Turns the MiST PS/2 keyboard stream into the held-key vector (kbjoy)
// that the arcade top level ORs with the real joystick ports.
module ps2_joy_decoder
  import ps2_joy_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 18000
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ps2_kbd_clk,
  input  logic             ps2_kbd_data,
  output logic [JOY_W-1:0] joystick,
  output logic [7:0]       scan_code,
  output logic             scan_valid,
  output logic             frame_err
);

  logic [7:0]       rxByte;
  logic             byteStb;
  logic             errStb;
  logic             ext_q;
  logic             brk_q;
  logic [JOY_W-1:0] joy_q;
  keyHit_t          keyHit;

  ps2_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk_i     (clk_sys),
    .reset_i   (reset),
    .ps2Clk_i  (ps2_kbd_clk),
    .ps2Data_i (ps2_kbd_data),
    .rxByte_o  (rxByte),
    .byteStb_o (byteStb),
    .errStb_o  (errStb)
  );

  assign keyHit = mapKey(ext_q, rxByte);

  // Any framing error drops pending prefixes so a half-seen E0/F0 cannot
  // attach itself to an unrelated later key.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      joy_q <= '0;
    end else if (errStb) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (byteStb) begin
      case (rxByte)
        SC_EXT: ext_q <= 1'b1;
        SC_BRK: brk_q <= 1'b1;
        SC_PAUSE, SC_ACK, SC_BAT: begin
        end
        SC_OVR0, SC_OVR1: begin
          joy_q <= '0;
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
        default: begin
          if (keyHit.hit) begin
            joy_q[keyHit.bitIdx] <= !brk_q;
          end
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
      endcase
    end
  end

  assign joystick   = joy_q;
  assign scan_code  = rxByte;
  assign scan_valid = byteStb;
  assign frame_err  = errStb;

endmodule
